flex_updown_counter: RTL and testbench
======================================

Name: flex_updown_counter

Overview:
- Parametrised up/down successor to the team's flex counter, with synchronous load, a wrap pulse and an optional prescaler.
- Count range is 1..rollover_val in both directions, matching the existing counter's up-count semantics.
- Used by timing, bit-period and packet-length logic in protocol blocks (UART/USB-style RX/TX controllers) that need count-down or preset counts.

Parameters:
- NUM_CNT_BITS, 4, width of count, load and rollover values; legal range ≥2.
- PRESCALE_DIV, 4, prescaler divide ratio, ≥1; used only when FLEX_CNT_PRESCALE_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear, highest priority.
- load  in  1  synchronous load of load_val.
- count_enable  in  1  advance request.
- count_down  in  1  direction; 0 = up, 1 = down; sampled every cycle.
- load_val  in  NUM_CNT_BITS  preset value.
- rollover_val  in  NUM_CNT_BITS  terminal/wrap value; may change at any time.
- count_out  out  NUM_CNT_BITS  registered count.
- rollover_flag  out  1  registered level flag: count_out is at the terminal value for the current direction.
- wrap_pulse  out  1  registered one-cycle pulse in the cycle after a wrap occurred.

Behaviour:
- Reset: count_out = 0, rollover_flag = 0, wrap_pulse = 0, prescaler = 0. Reset takes effect immediately, including mid-count or mid-load.
- All outputs are registered. Latency is one clk from input to count_out and flags. All three outputs are computed from the next count value, so they agree in the same cycle.
- Priority per cycle is clear > load > advance > hold.
- Clear:
  - count_out ← 0, rollover_flag ← 0, wrap_pulse ← 0.
  - Prescaler ← 0.
- Load:
  - count_out ← load_val, unclamped.
  - wrap_pulse ← 0; flag evaluated on load_val.
  - Prescaler ← 0; count_enable is ignored that cycle.
- Advance occurs when count_enable = 1 and the prescaler tick is true. The tick is always true without the optional feature.
  - Up: if count_out ≥ rollover_val, next = 1 and wrap; else next = count_out + 1.
  - Down: if count_out ≤ 1, next = rollover_val and wrap; else next = count_out − 1.
- Arithmetic is NUM_CNT_BITS wide, unsigned. No arithmetic overflow is possible because wrap is detected before increment.
- rollover_val = 0: an advance produces next = 0 and no wrap_pulse. rollover_flag = 1 in up mode (count equals rollover_val) and 0 in down mode.
- rollover_flag:
  - Up: set when next == rollover_val.
  - Down: set when next == 1.
  - Otherwise 0; recomputed every cycle, including hold cycles.
  - Changing count_down or rollover_val therefore updates the flag one cycle later.
- wrap_pulse is 1 only for the cycle following an advance that wrapped. Consecutive wraps (rollover_val = 1, enable held) give wrap_pulse high continuously.
- If rollover_val is lowered below count_out:
  - Up: the next advance wraps to 1.
  - Down: the count decrements normally.
- Direction change mid-count continues from the current value with no skip.

Optional Feature:
- Macro: FLEX_CNT_PRESCALE_EN.
- Defined:
  - An internal prescaler counts enabled cycles 0..PRESCALE_DIV−1.
  - Tick is true when prescaler == PRESCALE_DIV−1 and count_enable = 1; the prescaler then returns to 0.
  - count_out advances only on tick.
  - The prescaler holds when count_enable = 0 and is zeroed by reset, clear and load.
  - PRESCALE_DIV = 1 behaves identically to the undefined case.
- Undefined: no prescaler logic; every enabled cycle advances; the PRESCALE_DIV value is ignored.

Decomposition:
- Package flex_cnt_pkg:
  - typedef enum logic {CNT_UP = 1'b0, CNT_DOWN = 1'b1} cnt_dir_t.
  - Localparam CNT_RESET_VAL = 0.
- Sub-module flex_prescaler: parametrised divider producing tick. Instantiated only under FLEX_CNT_PRESCALE_EN.
- Next-state logic and flag logic stay in the top block.

Test Plan:
- Up wrap: reset, NUM_CNT_BITS = 4, rollover_val = 5, enable held 7 cycles.
  - Required: count 1,2,3,4,5,1,2.
  - rollover_flag high only while count = 5; wrap_pulse high only in the cycle count = 1 after wrap.
- Down wrap: load_val = 3, then count_down = 1, enable held, rollover_val = 5.
  - Required: count 3,2,1,5,4.
  - rollover_flag high while count = 1; wrap_pulse with the first count = 5.
- Priority: clear = load = count_enable = 1, load_val = 9.
  - Required: count 0, flags 0.
  - Next cycle with load = 1 and enable = 1: count 9, no increment.
- Boundaries:
  - rollover_val = 0 with enable: count 0, wrap_pulse never asserts.
  - rollover_val lowered from 10 to 4 at count 7 (up): next count 1 with wrap_pulse.
- Async reset mid-count: count = 6, assert n_rst between edges.
  - Required: outputs 0 immediately; count resumes from 1 after release with enable.
- With FLEX_CNT_PRESCALE_EN, PRESCALE_DIV = 3:
  - Enable held 9 cycles: count advances every 3rd cycle to 3.
  - Drop enable for 2 cycles mid-interval: tick is delayed by exactly 2 cycles.

Source files
------------

// File: rtl/flex_cnt_pkg.sv
// Shared types and constants for the flex up/down counter.
// Exports cnt_dir_t (count direction) and CNT_RESET_VAL.
package flex_cnt_pkg;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_t;

  localparam int CNT_RESET_VAL = 0;

endpackage

// File: rtl/flex_updown_counter_if.sv
// Control/status bundle of the flex up/down counter.
// master drives clear/load/enable/direction/values; slave returns count and flags.
interface flex_updown_counter_if #(
  parameter int W = 4
);

  logic         clear;
  logic         load;
  logic         count_enable;
  logic         count_down;
  logic [W-1:0] load_val;
  logic [W-1:0] rollover_val;
  logic [W-1:0] count_out;
  logic         rollover_flag;
  logic         wrap_pulse;

  modport master (
    output clear,
    output load,
    output count_enable,
    output count_down,
    output load_val,
    output rollover_val,
    input  count_out,
    input  rollover_flag,
    input  wrap_pulse
  );

  modport slave (
    input  clear,
    input  load,
    input  count_enable,
    input  count_down,
    input  load_val,
    input  rollover_val,
    output count_out,
    output rollover_flag,
    output wrap_pulse
  );

endinterface

// File: rtl/flex_prescaler.sv
// Divide-by-DIV enable prescaler: tick_o pulses on every DIV-th enabled cycle.
// Ports: clk, n_rst (async low), clr_i (sync zero), en_i (count), tick_o.
module flex_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] pre_q;
  logic [W-1:0] pre_d;
  logic         last;

  assign last   = (pre_q == LAST);
  assign tick_o = en_i & last;

  always_comb begin
    pre_d = pre_q;
    if (clr_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = last ? '0 : pre_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/flex_updown_counter.sv
// Up/down counter over 1..rollover_val with sync clear/load and wrap pulse.
// Ports: clk, n_rst (async low), bus (slave). Macro FLEX_CNT_PRESCALE_EN adds prescaler.
module flex_updown_counter
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int PRESCALE_DIV = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  flex_updown_counter_if.slave  bus
);

  localparam int N = NUM_CNT_BITS;
  localparam logic [N-1:0] ZERO = N'(CNT_RESET_VAL);
  localparam logic [N-1:0] ONE  = N'(1);

  if (NUM_CNT_BITS < 2) begin : g_bad_width
    $error("NUM_CNT_BITS must be >= 2");
  end
  if (PRESCALE_DIV < 1) begin : g_bad_div
    $error("PRESCALE_DIV must be >= 1");
  end

  logic [N-1:0] cnt_q, cnt_d;
  logic         flag_q, flag_d;
  logic         wrap_q, wrap_d;
  logic         tick;
  logic         adv;
  logic         rv_zero;
  cnt_dir_t     dir;

`ifdef FLEX_CNT_PRESCALE_EN
  flex_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_pre (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr_i  (bus.clear | bus.load),
    .en_i   (bus.count_enable),
    .tick_o (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign dir     = cnt_dir_t'(bus.count_down);
  assign adv     = bus.count_enable & tick;
  assign rv_zero = (bus.rollover_val == ZERO);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.clear) begin
      cnt_d = ZERO;
    end else if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (adv) begin
      // A zero range pins the count at zero and never wraps.
      if (rv_zero) begin
        cnt_d = ZERO;
      end else if (dir == CNT_UP) begin
        if (cnt_q >= bus.rollover_val) begin
          cnt_d  = ONE;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q <= ONE) begin
          cnt_d  = bus.rollover_val;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_comb begin
    flag_d = 1'b0;
    if (!bus.clear) begin
      unique case (dir)
        CNT_UP:   flag_d = (cnt_d == bus.rollover_val);
        CNT_DOWN: flag_d = (cnt_d == ONE);
        default:  flag_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= ZERO;
      flag_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.count_out     = cnt_q;
  assign bus.rollover_flag = flag_q;
  assign bus.wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Self-checking bench for flex_updown_counter.
// Vector table plus hand sequences; expectations flow through a scoreboard queue.
module tb_flex_updown_counter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  flex_updown_counter_if #(.W(N)) bus ();

  flex_updown_counter #(
    .NUM_CNT_BITS (N),
    .PRESCALE_DIV (3)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N-1:0] c;
    logic         f;
    logic         w;
  } exp_t;

  typedef struct {
    string        nm;
    logic         clr;
    logic         ld;
    logic         en;
    logic         dn;
    logic [N-1:0] lv;
    logic [N-1:0] rv;
    exp_t         e;
  } vec_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(string nm, logic clr, logic ld, logic en,
                              logic dn, int lv, int rv,
                              int c, logic f, logic w);
    vec_t v;
    v.nm  = nm;
    v.clr = clr;
    v.ld  = ld;
    v.en  = en;
    v.dn  = dn;
    v.lv  = N'(lv);
    v.rv  = N'(rv);
    v.e.c = N'(c);
    v.e.f = f;
    v.e.w = w;
    vt.push_back(v);
  endfunction

  function automatic exp_t mk(int c, logic f, logic w);
    exp_t e;
    e.c = N'(c);
    e.f = f;
    e.w = w;
    return e;
  endfunction

  task automatic chk(string nm, exp_t e);
    exp_t a;
    a.c = bus.count_out;
    a.f = bus.rollover_flag;
    a.w = bus.wrap_pulse;
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got cnt=%0d flag=%b wrap=%b, want cnt=%0d flag=%b wrap=%b",
               nm, a.c, a.f, a.w, e.c, e.f, e.w);
    end
  endtask

  task automatic step(vec_t v);
    exp_t e;
    bus.clear        = v.clr;
    bus.load         = v.ld;
    bus.count_enable = v.en;
    bus.count_down   = v.dn;
    bus.load_val     = v.lv;
    bus.rollover_val = v.rv;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, want 1 entry", v.nm);
    end else begin
      e = sb.pop_front();
      chk(v.nm, e);
    end
  endtask

  task automatic run_one(string nm, logic clr, logic ld, logic en,
                         logic dn, int lv, int rv,
                         int c, logic f, logic w);
    vec_t v;
    v.nm  = nm;
    v.clr = clr;
    v.ld  = ld;
    v.en  = en;
    v.dn  = dn;
    v.lv  = N'(lv);
    v.rv  = N'(rv);
    v.e   = mk(c, f, w);
    step(v);
  endtask

  initial begin
    // up wrap, rollover 5
    add("up1",  0,0,1,0, 0,5, 1,0,0);
    add("up2",  0,0,1,0, 0,5, 2,0,0);
    add("up3",  0,0,1,0, 0,5, 3,0,0);
    add("up4",  0,0,1,0, 0,5, 4,0,0);
    add("up5",  0,0,1,0, 0,5, 5,1,0);
    add("up_wr",0,0,1,0, 0,5, 1,0,1);
    add("up2b", 0,0,1,0, 0,5, 2,0,0);
    // down wrap from load 3
    add("dn_ld",0,1,0,1, 3,5, 3,0,0);
    add("dn2",  0,0,1,1, 0,5, 2,0,0);
    add("dn1",  0,0,1,1, 0,5, 1,1,0);
    add("dn_wr",0,0,1,1, 0,5, 5,0,1);
    add("dn4",  0,0,1,1, 0,5, 4,0,0);
    // priority and hold-cycle flag update
    add("pri_all",  1,1,1,0, 9,5, 0,0,0);
    add("pri_ld",   0,1,1,0, 9,5, 9,0,0);
    add("hold_flag",0,0,0,0, 0,9, 9,1,0);
    // rollover_val = 0
    add("clr0",  1,0,0,0, 0,0, 0,0,0);
    add("rv0_a", 0,0,1,0, 0,0, 0,1,0);
    add("rv0_b", 0,0,1,0, 0,0, 0,1,0);
    add("rv0_dn",0,0,1,1, 0,0, 0,0,0);
    // rollover lowered under count
    add("ld7",    0,1,0,0, 7,10, 7,0,0);
    add("low_up", 0,0,1,0, 0,4,  1,0,1);
    add("ld9",    0,1,0,1, 9,4,  9,0,0);
    add("low_dn", 0,0,1,1, 0,4,  8,0,0);
    // direction change
    add("dir_up", 0,0,1,0, 0,10, 9,0,0);
    add("dir_dn", 0,0,1,1, 0,10, 8,0,0);
    // rollover_val = 1: continuous wrap
    add("ld1",  0,1,0,0, 1,1, 1,1,0);
    add("rv1_a",0,0,1,0, 0,1, 1,1,1);
    add("rv1_b",0,0,1,0, 0,1, 1,1,1);

    bus.clear        = 1'b0;
    bus.load         = 1'b0;
    bus.count_enable = 1'b0;
    bus.count_down   = 1'b0;
    bus.load_val     = '0;
    bus.rollover_val = N'(5);

    #12;
    chk("reset", mk(0, 0, 0));
    n_rst = 1'b1;

    foreach (vt[i]) step(vt[i]);

    // async reset mid-count
    run_one("ar_clr", 1,0,0,0, 0,10, 0,0,0);
    for (int i = 1; i <= 6; i++) begin
      run_one("ar_cnt", 0,0,1,0, 0,10, i,0,0);
    end
    #3;
    n_rst = 1'b0;
    #1;
    chk("async_rst", mk(0, 0, 0));
    #1;
    n_rst = 1'b1;
    run_one("ar_resume", 0,0,1,0, 0,10, 1,0,0);

`ifdef FLEX_CNT_PRESCALE_EN
    run_one("ps_clr", 1,0,0,0, 0,10, 0,0,0);
    for (int i = 1; i <= 9; i++) begin
      run_one("ps_div3", 0,0,1,0, 0,10, i / 3,0,0);
    end
    run_one("ps_en1",  0,0,1,0, 0,10, 3,0,0);
    run_one("ps_off1", 0,0,0,0, 0,10, 3,0,0);
    run_one("ps_off2", 0,0,0,0, 0,10, 3,0,0);
    run_one("ps_en2",  0,0,1,0, 0,10, 3,0,0);
    run_one("ps_tick", 0,0,1,0, 0,10, 4,0,0);
`endif

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_drain: %0d left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
